// File: rtl/issue_pkg.sv
// Shared issue-stage definitions: widths, entry field positions and the
// packed LSQ / IQ entry formats pushed by the dispatch router.
package issue_pkg;

    localparam int REG_SPEC_BITS = 6;
    localparam int ROB_PTR_BITS  = 6;
    localparam int PHYS_REGS     = 64;
    localparam int LSQ_DATA_W    = 72;
    localparam int IQ_DATA_W     = 64;

    // LSQ entry field LSB positions
    localparam int LSQ_INSTR_LSB = 0;
    localparam int LSQ_ROBP_LSB  = 32;
    localparam int LSQ_OP_LSB    = 38;
    localparam int LSQ_IMM_LSB   = 44;
    localparam int LSQ_SR_LSB    = 60;
    localparam int LSQ_DR_LSB    = 66;

    // IQ entry field LSB positions
    localparam int IQ_INSTR_LSB  = 0;
    localparam int IQ_ROBP_LSB   = 32;
    localparam int IQ_OP_LSB     = 38;
    localparam int IQ_SR1_LSB    = 44;
    localparam int IQ_R1_BIT     = 50;
    localparam int IQ_SR2_LSB    = 51;
    localparam int IQ_R2_BIT     = 57;
    localparam int IQ_DR_LSB     = 58;

    typedef struct packed {
        logic [REG_SPEC_BITS-1:0] dr;
        logic [REG_SPEC_BITS-1:0] sr;
        logic [15:0]              imm;
        logic [5:0]               op;
        logic [ROB_PTR_BITS-1:0]  robp;
        logic [31:0]              instr;
    } lsq_entry_t;

    typedef struct packed {
        logic [REG_SPEC_BITS-1:0] dr;
        logic                     r2;
        logic [REG_SPEC_BITS-1:0] sr2;
        logic                     r1;
        logic [REG_SPEC_BITS-1:0] sr1;
        logic [5:0]               op;
        logic [ROB_PTR_BITS-1:0]  robp;
        logic [31:0]              instr;
    } iq_entry_t;

endpackage

// File: rtl/dispatch_router_if.sv
// Rename-side handshake plus LSQ / IQ push ports of the dispatch router.
// master = rename / issue-stage side, slave = dispatch router.
interface dispatch_router_if;
    import issue_pkg::*;

    logic                     in_valid_IN;
    logic                     in_ready_OUT;
    logic [31:0]              in_instr_IN;
    logic [5:0]               in_op_IN;
    logic [15:0]              in_imm_IN;
    logic [REG_SPEC_BITS-1:0] in_src1_IN;
    logic [REG_SPEC_BITS-1:0] in_src2_IN;
    logic [REG_SPEC_BITS-1:0] in_dest_IN;
    logic                     in_is_mem_IN;
    logic                     LSQ_full_IN;
    logic                     IQ_full_IN;
    logic                     push_LSQ_OUT;
    logic                     push_IQ_OUT;
    logic [LSQ_DATA_W-1:0]    LSQ_Data_OUT;
    logic [IQ_DATA_W-1:0]     IQ_Data_OUT;

    modport master (
        output in_valid_IN, in_instr_IN, in_op_IN, in_imm_IN,
               in_src1_IN, in_src2_IN, in_dest_IN, in_is_mem_IN,
               LSQ_full_IN, IQ_full_IN,
        input  in_ready_OUT, push_LSQ_OUT, push_IQ_OUT,
               LSQ_Data_OUT, IQ_Data_OUT
    );

    modport slave (
        input  in_valid_IN, in_instr_IN, in_op_IN, in_imm_IN,
               in_src1_IN, in_src2_IN, in_dest_IN, in_is_mem_IN,
               LSQ_full_IN, IQ_full_IN,
        output in_ready_OUT, push_LSQ_OUT, push_IQ_OUT,
               LSQ_Data_OUT, IQ_Data_OUT
    );

endinterface

// File: rtl/busy_scoreboard.sv
// Physical-register busy scoreboard. Dispatch sets busy[dest]; each valid
// writeback/forward broadcast clears busy[tag]; set beats clear on the same
// register; flush clears everything. Read ports see same-cycle wakeups.
module busy_scoreboard
    import issue_pkg::*;
(
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     clear_all,
    input  logic                     set_en,
    input  logic [REG_SPEC_BITS-1:0] set_tag,
    input  logic [REG_SPEC_BITS-1:0] wake_tag_0,
    input  logic                     wake_vld_0,
    input  logic [REG_SPEC_BITS-1:0] wake_tag_1,
    input  logic                     wake_vld_1,
    input  logic [REG_SPEC_BITS-1:0] wake_tag_2,
    input  logic                     wake_vld_2,
    input  logic [REG_SPEC_BITS-1:0] rd_tag_1,
    input  logic [REG_SPEC_BITS-1:0] rd_tag_2,
    output logic                     rd_ready_1,
    output logic                     rd_ready_2
);

    logic [PHYS_REGS-1:0] busy_r;
    logic [PHYS_REGS-1:0] busy_nxt_s;
    logic [PHYS_REGS-1:0] wake_mask_s;
    logic [PHYS_REGS-1:0] set_mask_s;

    // Decode broadcasts and the dispatch set into masks, then next busy state
    always_comb begin
        wake_mask_s = (wake_vld_0 ? (64'd1 << wake_tag_0) : 64'd0)
                    | (wake_vld_1 ? (64'd1 << wake_tag_1) : 64'd0)
                    | (wake_vld_2 ? (64'd1 << wake_tag_2) : 64'd0);
        set_mask_s  = set_en ? (64'd1 << set_tag) : 64'd0;
        if (clear_all) begin
            busy_nxt_s = '0;
        end else begin
            busy_nxt_s = (busy_r & ~wake_mask_s) | set_mask_s;
        end
    end

    // Busy vector register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Ready lookup: register 0 never waits; a same-cycle broadcast bypasses
    always_comb begin
        rd_ready_1 = (rd_tag_1 == 6'd0) | ~busy_r[rd_tag_1] | wake_mask_s[rd_tag_1];
        rd_ready_2 = (rd_tag_2 == 6'd0) | ~busy_r[rd_tag_2] | wake_mask_s[rd_tag_2];
    end

endmodule

// File: rtl/dispatch_router.sv
// Dispatch router: accepts one renamed instruction per cycle, stamps it with
// the ROB pointer and pushes it (registered) to the LSQ or the IQ.
// Optional feature macro: DISPATCH_PERF_CNT_EN adds saturating stall and
// dispatch counters (stall_cycles_OUT, dispatched_OUT).
module dispatch_router
    import issue_pkg::*;
(
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     FREEZE,
    input  logic                     ROB_full_IN,
    dispatch_router_if.slave         bus,
    input  logic [REG_SPEC_BITS-1:0] fwd_reg_1,
    input  logic [REG_SPEC_BITS-1:0] fwd_reg_2,
    input  logic [REG_SPEC_BITS-1:0] LS_fwd_reg,
    input  logic                     fwd_data_1_WB,
    input  logic                     fwd_data_2_WB,
    input  logic                     LS_fwd_data_WB,
    input  logic                     flush_IN,
    input  logic [ROB_PTR_BITS-1:0]  flush_robp_IN
`ifdef DISPATCH_PERF_CNT_EN
    ,
    output logic [31:0]              stall_cycles_OUT,
    output logic [31:0]              dispatched_OUT
`endif
);

    logic                    target_full_s;
    logic                    ready_s;
    logic                    accept_s;
    logic                    rdy1_s;
    logic                    rdy2_s;
    logic [ROB_PTR_BITS-1:0] robp_r;
    logic                    push_lsq_r;
    logic                    push_iq_r;
    lsq_entry_t              lsq_entry_s;
    iq_entry_t               iq_entry_s;
    lsq_entry_t              lsq_data_r;
    iq_entry_t               iq_data_r;

    // Accept rule: a full queue only stalls instructions headed for it
    always_comb begin
        target_full_s = bus.in_is_mem_IN ? bus.LSQ_full_IN : bus.IQ_full_IN;
        ready_s       = ~FREEZE & ~flush_IN & ~ROB_full_IN & ~target_full_s;
        accept_s      = bus.in_valid_IN & ready_s;
    end

    busy_scoreboard u_sb (
        .CLK        (CLK),
        .RESET      (RESET),
        .clear_all  (flush_IN),
        .set_en     (accept_s && (bus.in_dest_IN != 6'd0)),
        .set_tag    (bus.in_dest_IN),
        .wake_tag_0 (fwd_reg_1),
        .wake_vld_0 (fwd_data_1_WB),
        .wake_tag_1 (fwd_reg_2),
        .wake_vld_1 (fwd_data_2_WB),
        .wake_tag_2 (LS_fwd_reg),
        .wake_vld_2 (LS_fwd_data_WB),
        .rd_tag_1   (bus.in_src1_IN),
        .rd_tag_2   (bus.in_src2_IN),
        .rd_ready_1 (rdy1_s),
        .rd_ready_2 (rdy2_s)
    );

    // Pack the incoming instruction into both entry formats
    always_comb begin
        lsq_entry_s       = '0;
        lsq_entry_s.instr = bus.in_instr_IN;
        lsq_entry_s.robp  = robp_r;
        lsq_entry_s.op    = bus.in_op_IN;
        lsq_entry_s.imm   = bus.in_imm_IN;
        lsq_entry_s.sr    = bus.in_src1_IN;
        lsq_entry_s.dr    = bus.in_dest_IN;

        iq_entry_s        = '0;
        iq_entry_s.instr  = bus.in_instr_IN;
        iq_entry_s.robp   = robp_r;
        iq_entry_s.op     = bus.in_op_IN;
        iq_entry_s.sr1    = bus.in_src1_IN;
        iq_entry_s.r1     = rdy1_s;
        iq_entry_s.sr2    = bus.in_src2_IN;
        iq_entry_s.r2     = rdy2_s;
        iq_entry_s.dr     = bus.in_dest_IN;
    end

    // ROB pointer and registered push ports; flush outranks any accept
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            robp_r     <= '0;
            push_lsq_r <= 1'b0;
            push_iq_r  <= 1'b0;
            lsq_data_r <= '0;
            iq_data_r  <= '0;
        end else if (flush_IN) begin
            robp_r     <= flush_robp_IN;
            push_lsq_r <= 1'b0;
            push_iq_r  <= 1'b0;
        end else if (accept_s) begin
            robp_r <= robp_r + 6'd1;
            if (bus.in_is_mem_IN) begin
                push_lsq_r <= 1'b1;
                push_iq_r  <= 1'b0;
                lsq_data_r <= lsq_entry_s;
            end else begin
                push_lsq_r <= 1'b0;
                push_iq_r  <= 1'b1;
                iq_data_r  <= iq_entry_s;
            end
        end else begin
            push_lsq_r <= 1'b0;
            push_iq_r  <= 1'b0;
        end
    end

    assign bus.in_ready_OUT = ready_s;
    assign bus.push_LSQ_OUT = push_lsq_r;
    assign bus.push_IQ_OUT  = push_iq_r;
    assign bus.LSQ_Data_OUT = lsq_data_r;
    assign bus.IQ_Data_OUT  = iq_data_r;

`ifdef DISPATCH_PERF_CNT_EN
    logic        stall_s;
    logic [31:0] stall_cnt_r;
    logic [31:0] disp_cnt_r;

    assign stall_s = bus.in_valid_IN & ~ready_s & ~FREEZE;

    // Saturating performance counters, cleared only by reset
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stall_cnt_r <= '0;
            disp_cnt_r  <= '0;
        end else begin
            if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (accept_s && (disp_cnt_r != 32'hFFFF_FFFF)) begin
                disp_cnt_r <= disp_cnt_r + 32'd1;
            end else begin
                disp_cnt_r <= disp_cnt_r;
            end
        end
    end

    assign stall_cycles_OUT = stall_cnt_r;
    assign dispatched_OUT   = disp_cnt_r;
`endif

endmodule

// File: tb/tb_dispatch_router.sv
// Self-checking bench for dispatch_router: directed scenarios plus a
// randomized run against a behavioural model of the dispatch rules.
`timescale 1ns/1ps
module tb_dispatch_router;
    import issue_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       FREEZE = 1'b0;
    logic       ROB_full_IN = 1'b0;
    logic [5:0] fwd_reg_1 = 6'd0, fwd_reg_2 = 6'd0, LS_fwd_reg = 6'd0;
    logic       fwd_data_1_WB = 1'b0, fwd_data_2_WB = 1'b0, LS_fwd_data_WB = 1'b0;
    logic       flush_IN = 1'b0;
    logic [5:0] flush_robp_IN = 6'd0;
`ifdef DISPATCH_PERF_CNT_EN
    logic [31:0] stall_cycles_OUT, dispatched_OUT;
    int m_stall = 0, m_disp = 0;
`endif

    dispatch_router_if bus();

    always #5 CLK = ~CLK;

    dispatch_router dut (
        .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .ROB_full_IN(ROB_full_IN),
        .bus(bus),
        .fwd_reg_1(fwd_reg_1), .fwd_reg_2(fwd_reg_2), .LS_fwd_reg(LS_fwd_reg),
        .fwd_data_1_WB(fwd_data_1_WB), .fwd_data_2_WB(fwd_data_2_WB),
        .LS_fwd_data_WB(LS_fwd_data_WB),
        .flush_IN(flush_IN), .flush_robp_IN(flush_robp_IN)
`ifdef DISPATCH_PERF_CNT_EN
        , .stall_cycles_OUT(stall_cycles_OUT), .dispatched_OUT(dispatched_OUT)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    bit          m_busy [64];
    int          m_robp;
    logic [71:0] m_lsq;
    logic [63:0] m_iq;
    logic        e_push_lsq, e_push_iq, e_ready, e_acc, o_ready;

    function automatic bit ready_of(input logic [5:0] s);
        return (s == 6'd0) || !m_busy[s]
            || (fwd_data_1_WB && fwd_reg_1 == s)
            || (fwd_data_2_WB && fwd_reg_2 == s)
            || (LS_fwd_data_WB && LS_fwd_reg == s);
    endfunction

    task automatic model_reset();
        m_busy = '{default: 1'b0};
        m_robp = 0;
        m_lsq = 72'd0;
        m_iq = 64'd0;
        e_push_lsq = 1'b0;
        e_push_iq = 1'b0;
    endtask

    task automatic idle();
        bus.in_valid_IN = 1'b0; bus.in_is_mem_IN = 1'b0;
        bus.LSQ_full_IN = 1'b0; bus.IQ_full_IN = 1'b0;
        FREEZE = 1'b0; ROB_full_IN = 1'b0; flush_IN = 1'b0;
        fwd_data_1_WB = 1'b0; fwd_data_2_WB = 1'b0; LS_fwd_data_WB = 1'b0;
    endtask

    task automatic set_instr(input bit v, input bit mem, input logic [5:0] s1,
                             input logic [5:0] s2, input logic [5:0] d);
        bus.in_valid_IN = v; bus.in_is_mem_IN = mem;
        bus.in_src1_IN = s1; bus.in_src2_IN = s2; bus.in_dest_IN = d;
        bus.in_instr_IN = $urandom; bus.in_op_IN = 6'($urandom);
        bus.in_imm_IN = 16'($urandom);
    endtask

    // Sample ready, predict the next-cycle outputs, advance one clock
    task automatic step();
        logic [5:0] rp;
        bit r1, r2;
        #1;
        o_ready = bus.in_ready_OUT;
        e_ready = !FREEZE && !flush_IN && !ROB_full_IN &&
                  !(bus.in_is_mem_IN ? bus.LSQ_full_IN : bus.IQ_full_IN);
        e_acc = bus.in_valid_IN && e_ready;
        rp = 6'(m_robp);
        r1 = ready_of(bus.in_src1_IN);
        r2 = ready_of(bus.in_src2_IN);
        e_push_lsq = e_acc && bus.in_is_mem_IN;
        e_push_iq  = e_acc && !bus.in_is_mem_IN;
        if (e_push_lsq)
            m_lsq = {bus.in_dest_IN, bus.in_src1_IN, bus.in_imm_IN, bus.in_op_IN, rp, bus.in_instr_IN};
        if (e_push_iq)
            m_iq = {bus.in_dest_IN, r2, bus.in_src2_IN, r1, bus.in_src1_IN, bus.in_op_IN, rp, bus.in_instr_IN};
`ifdef DISPATCH_PERF_CNT_EN
        if (bus.in_valid_IN && !e_ready && !FREEZE) m_stall++;
        if (e_acc) m_disp++;
`endif
        if (flush_IN) begin
            m_robp = flush_robp_IN;
            m_busy = '{default: 1'b0};
        end else begin
            if (fwd_data_1_WB) m_busy[fwd_reg_1] = 1'b0;
            if (fwd_data_2_WB) m_busy[fwd_reg_2] = 1'b0;
            if (LS_fwd_data_WB) m_busy[LS_fwd_reg] = 1'b0;
            if (e_acc && bus.in_dest_IN != 6'd0) m_busy[bus.in_dest_IN] = 1'b1;
            if (e_acc) m_robp = (m_robp + 1) % 64;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        idle();
        RESET = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.push_LSQ_OUT !== 1'b0 || bus.push_IQ_OUT !== 1'b0 ||
            bus.LSQ_Data_OUT !== 72'd0 || bus.IQ_Data_OUT !== 64'd0) begin
            errors++;
            $display("FAIL reset_outputs: got pl=%b pi=%b lsq=%h iq=%h, want all 0",
                     bus.push_LSQ_OUT, bus.push_IQ_OUT, bus.LSQ_Data_OUT, bus.IQ_Data_OUT);
        end
    endtask

    task automatic test_alu_and_wake();
        set_instr(1, 0, 6'd5, 6'd7, 6'd9);
        step();
        checks++;
        if (bus.push_IQ_OUT !== 1'b1 || bus.push_LSQ_OUT !== 1'b0 || bus.IQ_Data_OUT[37:32] !== 6'd0 ||
            bus.IQ_Data_OUT[50] !== 1'b1 || bus.IQ_Data_OUT[57] !== 1'b1 || bus.IQ_Data_OUT[63:58] !== 6'd9) begin
            errors++;
            $display("FAIL alu_first: got pi=%b pl=%b iq=%h, want pi=1 robp=0 r1=r2=1 dr=9",
                     bus.push_IQ_OUT, bus.push_LSQ_OUT, bus.IQ_Data_OUT);
        end
        set_instr(1, 0, 6'd9, 6'd0, 6'd0);
        step();
        checks++;
        if (bus.IQ_Data_OUT[50] !== 1'b0 || bus.IQ_Data_OUT !== m_iq) begin
            errors++;
            $display("FAIL busy_src: got iq=%h, want %h (r1=0)", bus.IQ_Data_OUT, m_iq);
        end
        set_instr(1, 0, 6'd9, 6'd0, 6'd0);
        fwd_reg_1 = 6'd9; fwd_data_1_WB = 1'b1;
        step();
        fwd_data_1_WB = 1'b0;
        checks++;
        if (bus.IQ_Data_OUT[50] !== 1'b1 || bus.IQ_Data_OUT !== m_iq) begin
            errors++;
            $display("FAIL wake_bypass: got iq=%h, want %h (r1=1)", bus.IQ_Data_OUT, m_iq);
        end
        set_instr(1, 0, 6'd9, 6'd9, 6'd0);
        step();
        checks++;
        if (bus.IQ_Data_OUT[50] !== 1'b1 || bus.IQ_Data_OUT[57] !== 1'b1) begin
            errors++;
            $display("FAIL wake_cleared: got iq=%h, want r1=r2=1", bus.IQ_Data_OUT);
        end
    endtask

    task automatic test_full_routing();
        set_instr(1, 1, 6'd3, 6'd4, 6'd6);
        bus.LSQ_full_IN = 1'b1;
        step();
        checks++;
        if (o_ready !== 1'b0 || bus.push_LSQ_OUT !== 1'b0 || bus.push_IQ_OUT !== 1'b0) begin
            errors++;
            $display("FAIL lsq_full_stall: got rdy=%b pl=%b pi=%b, want 0 0 0",
                     o_ready, bus.push_LSQ_OUT, bus.push_IQ_OUT);
        end
        set_instr(1, 0, 6'd3, 6'd4, 6'd6);
        step();
        checks++;
        if (o_ready !== 1'b1 || bus.push_IQ_OUT !== 1'b1 || bus.IQ_Data_OUT !== m_iq) begin
            errors++;
            $display("FAIL iq_past_lsq_full: got rdy=%b pi=%b iq=%h, want 1 1 %h",
                     o_ready, bus.push_IQ_OUT, bus.IQ_Data_OUT, m_iq);
        end
        bus.LSQ_full_IN = 1'b0;
        bus.IQ_full_IN = 1'b1;
        set_instr(1, 1, 6'd2, 6'd0, 6'd0);
        step();
        checks++;
        if (o_ready !== 1'b1 || bus.push_LSQ_OUT !== 1'b1 || bus.LSQ_Data_OUT !== m_lsq ||
            bus.IQ_Data_OUT !== m_iq) begin
            errors++;
            $display("FAIL lsq_past_iq_full: got rdy=%b pl=%b lsq=%h iq=%h, want 1 1 %h %h",
                     o_ready, bus.push_LSQ_OUT, bus.LSQ_Data_OUT, bus.IQ_Data_OUT, m_lsq, m_iq);
        end
        bus.IQ_full_IN = 1'b0;
        FREEZE = 1'b1;
        step();
        FREEZE = 1'b0;
        checks++;
        if (o_ready !== 1'b0 || bus.push_LSQ_OUT !== 1'b0 || bus.LSQ_Data_OUT !== m_lsq) begin
            errors++;
            $display("FAIL freeze_hold: got rdy=%b pl=%b lsq=%h, want 0 0 %h",
                     o_ready, bus.push_LSQ_OUT, bus.LSQ_Data_OUT, m_lsq);
        end
    endtask

    task automatic test_rob_wrap();
        logic [5:0] got, want;
        do_reset();
        for (int i = 0; i < 65; i++) begin
            set_instr(1, 1'($urandom), 6'd0, 6'd0, 6'd0);
            step();
            got  = bus.push_LSQ_OUT ? bus.LSQ_Data_OUT[37:32] : bus.IQ_Data_OUT[37:32];
            want = 6'(i % 64);
            checks++;
            if ((bus.push_LSQ_OUT ^ bus.push_IQ_OUT) !== 1'b1 || got !== want) begin
                errors++;
                $display("FAIL rob_wrap[%0d]: got robp=%0d pl=%b pi=%b, want robp=%0d one strobe",
                         i, got, bus.push_LSQ_OUT, bus.push_IQ_OUT, want);
            end
        end
        ROB_full_IN = 1'b1;
        set_instr(1, 0, 6'd0, 6'd0, 6'd0);
        step();
        ROB_full_IN = 1'b0;
        checks++;
        if (o_ready !== 1'b0 || bus.push_IQ_OUT !== 1'b0) begin
            errors++;
            $display("FAIL rob_full: got rdy=%b pi=%b, want 0 0", o_ready, bus.push_IQ_OUT);
        end
    endtask

    task automatic test_set_wins();
        set_instr(1, 0, 6'd0, 6'd0, 6'd12);
        LS_fwd_reg = 6'd12; LS_fwd_data_WB = 1'b1;
        step();
        LS_fwd_data_WB = 1'b0;
        set_instr(1, 0, 6'd12, 6'd0, 6'd0);
        step();
        checks++;
        if (bus.IQ_Data_OUT[50] !== 1'b0 || bus.IQ_Data_OUT !== m_iq) begin
            errors++;
            $display("FAIL set_wins: got iq=%h, want %h (r1=0)", bus.IQ_Data_OUT, m_iq);
        end
    endtask

    task automatic test_flush();
        set_instr(1, 0, 6'd0, 6'd0, 6'd20);
        step();
        set_instr(1, 0, 6'd1, 6'd2, 6'd3);
        flush_IN = 1'b1; flush_robp_IN = 6'd17;
        step();
        flush_IN = 1'b0;
        checks++;
        if (o_ready !== 1'b0 || bus.push_IQ_OUT !== 1'b0 || bus.push_LSQ_OUT !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_push: got rdy=%b pi=%b pl=%b, want 0 0 0",
                     o_ready, bus.push_IQ_OUT, bus.push_LSQ_OUT);
        end
        set_instr(1, 0, 6'd20, 6'd12, 6'd0);
        step();
        checks++;
        if (bus.IQ_Data_OUT[37:32] !== 6'd17 || bus.IQ_Data_OUT[50] !== 1'b1 ||
            bus.IQ_Data_OUT[57] !== 1'b1) begin
            errors++;
            $display("FAIL flush_restart: got iq=%h, want robp=17 r1=r2=1", bus.IQ_Data_OUT);
        end
    endtask

    task automatic test_reset_mid();
        set_instr(1, 1, 6'd4, 6'd0, 6'd5);
        step();
        idle();
        checks++;
        if (bus.push_LSQ_OUT !== 1'b1) begin
            errors++;
            $display("FAIL pending_push: got pl=%b, want 1", bus.push_LSQ_OUT);
        end
        RESET = 1'b0;
        #1;
        checks++;
        if (bus.push_LSQ_OUT !== 1'b0 || bus.push_IQ_OUT !== 1'b0 || bus.LSQ_Data_OUT !== 72'd0) begin
            errors++;
            $display("FAIL reset_async: got pl=%b pi=%b lsq=%h, want 0 0 0",
                     bus.push_LSQ_OUT, bus.push_IQ_OUT, bus.LSQ_Data_OUT);
        end
        model_reset();
        @(posedge CLK);
        #1;
        RESET = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_instr(($urandom_range(0, 3) != 0), 1'($urandom),
                      6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)));
            FREEZE = ($urandom_range(0, 9) == 0);
            flush_IN = ($urandom_range(0, 24) == 0);
            flush_robp_IN = 6'($urandom);
            ROB_full_IN = ($urandom_range(0, 9) == 0);
            bus.LSQ_full_IN = ($urandom_range(0, 4) == 0);
            bus.IQ_full_IN = ($urandom_range(0, 4) == 0);
            fwd_reg_1 = 6'($urandom_range(0, 15)); fwd_data_1_WB = 1'($urandom);
            fwd_reg_2 = 6'($urandom_range(0, 15)); fwd_data_2_WB = 1'($urandom);
            LS_fwd_reg = 6'($urandom_range(0, 15)); LS_fwd_data_WB = 1'($urandom);
            step();
            checks++;
            if (o_ready !== e_ready) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %b, want %b", i, o_ready, e_ready);
            end
            checks++;
            if (bus.push_LSQ_OUT !== e_push_lsq || bus.push_IQ_OUT !== e_push_iq ||
                bus.LSQ_Data_OUT !== m_lsq || bus.IQ_Data_OUT !== m_iq) begin
                errors++;
                $display("FAIL rand_out[%0d]: got pl=%b pi=%b lsq=%h iq=%h, want %b %b %h %h", i,
                         bus.push_LSQ_OUT, bus.push_IQ_OUT, bus.LSQ_Data_OUT, bus.IQ_Data_OUT,
                         e_push_lsq, e_push_iq, m_lsq, m_iq);
            end
        end
        idle();
`ifdef DISPATCH_PERF_CNT_EN
        checks++;
        if (stall_cycles_OUT !== 32'(m_stall) || dispatched_OUT !== 32'(m_disp)) begin
            errors++;
            $display("FAIL perf_cnt: got stall=%0d disp=%0d, want %0d %0d",
                     stall_cycles_OUT, dispatched_OUT, m_stall, m_disp);
        end
`endif
    endtask

    initial begin
        bus.in_src1_IN = 6'd0; bus.in_src2_IN = 6'd0; bus.in_dest_IN = 6'd0;
        bus.in_instr_IN = 32'd0; bus.in_op_IN = 6'd0; bus.in_imm_IN = 16'd0;
        idle();
        test_reset();
        test_alu_and_wake();
        test_full_routing();
        test_rob_wrap();
        test_set_wins();
        test_flush();
        test_reset_mid();
`ifdef DISPATCH_PERF_CNT_EN
        m_stall = 0;
        m_disp = 0;
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
